// File: rtl/vec_regfile_p.sv
`default_nettype none
// ============================================================================
// Module   : vec_regfile_p
// Purpose  : Parametrised vector register file for the vector datapath.
//            NUM_ELEMS element registers of ELEM_W bits, accessed as
//            LANES-wide vectors of consecutive elements with wrap-around.
//            Two combinational read ports, one masked valid/ready write
//            port, and a clear sequencer that zeroes one element per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   rd_addr_a  in   AW            base element address, read port A
//   rd_data_a  out  LANES*ELEM_W  lane k = element (rd_addr_a+k) mod NUM_ELEMS
//   rd_addr_b  in   AW            base element address, read port B
//   rd_data_b  out  LANES*ELEM_W  same layout as port A
//   wr_valid   in   1             write request
//   wr_ready   out  1             write can be accepted this cycle
//   wr_addr    in   AW            base element address for the write
//   wr_mask    in   LANES         per-lane write enable
//   wr_data    in   LANES*ELEM_W  write data, same lane layout as reads
//   clr_req    in   1             start a clear sweep (level-sampled)
//   busy       out  1             clear sweep in progress
// ----------------------------------------------------------------------------
// Configuration macro
//   VREG_BYPASS_EN : when defined, read lanes forward the value being written
//                    to their element in the same cycle (write data, or zero
//                    for the element being swept).
// ============================================================================
module vec_regfile_p #(
  parameter int ELEM_W    = 32,
  parameter int LANES     = 2,
  parameter int NUM_ELEMS = 8,
  parameter int AW        = $clog2(NUM_ELEMS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AW-1:0]           rd_addr_a,
  output logic [LANES*ELEM_W-1:0] rd_data_a,
  input  logic [AW-1:0]           rd_addr_b,
  output logic [LANES*ELEM_W-1:0] rd_data_b,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AW-1:0]           wr_addr,
  input  logic [LANES-1:0]        wr_mask,
  input  logic [LANES*ELEM_W-1:0] wr_data,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam logic [AW-1:0] c_last_idx = AW'(NUM_ELEMS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_sweep_idx;
  logic [AW-1:0] w_sweep_idx_nxt;
  logic          w_wr_fire;

  // Per-element update strobe and value. These are the single point where
  // both the sweep and the write port land, and the bypass path reuses them.
  logic [NUM_ELEMS-1:0] w_elem_we;
  logic [ELEM_W-1:0]    w_elem_wd [NUM_ELEMS];
  logic [ELEM_W-1:0]    w_mem     [NUM_ELEMS];

  assign w_wr_fire = wr_valid && wr_ready;

  // --------------------------------------------------------------------------
  // Clear sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    wr_ready        = 1'b0;
    busy            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A pending clear takes priority over a write in the same cycle.
        wr_ready = !clr_req;
        if (clr_req) begin
          w_state_nxt     = ST_SWEEP;
          w_sweep_idx_nxt = '0;
        end
      end
      ST_SWEEP: begin
        busy            = 1'b1;
        w_sweep_idx_nxt = r_sweep_idx + 1'b1;
        if (r_sweep_idx == c_last_idx) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_sweep_idx_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Element storage
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_elem
    localparam logic [AW-1:0] c_idx = AW'(i);

    logic              w_we;
    logic [ELEM_W-1:0] w_wd;
    logic [ELEM_W-1:0] r_elem;

    // Sweep and write never overlap: wr_ready is low for the whole sweep.
    // Lanes of one write hit distinct elements, so at most one lane matches.
    always_comb begin
      w_we = 1'b0;
      w_wd = '0;
      if (r_state == ST_SWEEP) begin
        w_we = (r_sweep_idx == c_idx);
      end else begin
        for (int k = 0; k < LANES; k++) begin
          if (w_wr_fire && wr_mask[k] && ((wr_addr + AW'(k)) == c_idx)) begin
            w_we = 1'b1;
            w_wd = wr_data[k*ELEM_W +: ELEM_W];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_elem <= '0;
      end else if (w_we) begin
        r_elem <= w_wd;
      end
    end

    assign w_elem_we[i] = w_we;
    assign w_elem_wd[i] = w_wd;
    assign w_mem[i]     = r_elem;
  end

  // --------------------------------------------------------------------------
  // Read ports: lane address is an AW-bit truncating add, giving wrap-around.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic [AW-1:0] c_off = AW'(k);

    logic [AW-1:0] w_addr_a;
    logic [AW-1:0] w_addr_b;

    assign w_addr_a = rd_addr_a + c_off;
    assign w_addr_b = rd_addr_b + c_off;

`ifdef VREG_BYPASS_EN
    assign rd_data_a[k*ELEM_W +: ELEM_W] =
      w_elem_we[w_addr_a] ? w_elem_wd[w_addr_a] : w_mem[w_addr_a];
    assign rd_data_b[k*ELEM_W +: ELEM_W] =
      w_elem_we[w_addr_b] ? w_elem_wd[w_addr_b] : w_mem[w_addr_b];
`else
    assign rd_data_a[k*ELEM_W +: ELEM_W] = w_mem[w_addr_a];
    assign rd_data_b[k*ELEM_W +: ELEM_W] = w_mem[w_addr_b];
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_regfile_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_regfile_p
// Purpose  : Directed self-checking bench for vec_regfile_p with the default
//            geometry (ELEM_W=32, LANES=2, NUM_ELEMS=8). Follows the
//            VREG_BYPASS_EN macro for same-cycle read expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_regfile_p;

  localparam int ELEM_W    = 32;
  localparam int LANES     = 2;
  localparam int NUM_ELEMS = 8;
  localparam int AW        = 3;

  logic                    clk;
  logic                    rst_n;
  logic [AW-1:0]           rd_addr_a;
  logic [LANES*ELEM_W-1:0] rd_data_a;
  logic [AW-1:0]           rd_addr_b;
  logic [LANES*ELEM_W-1:0] rd_data_b;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [AW-1:0]           wr_addr;
  logic [LANES-1:0]        wr_mask;
  logic [LANES*ELEM_W-1:0] wr_data;
  logic                    clr_req;
  logic                    busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [ELEM_W-1:0] exp_mem [NUM_ELEMS];

  vec_regfile_p #(
    .ELEM_W    (ELEM_W),
    .LANES     (LANES),
    .NUM_ELEMS (NUM_ELEMS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] vec(input int a);
    return {exp_mem[(a + 1) % NUM_ELEMS], exp_mem[a % NUM_ELEMS]};
  endfunction

  // One-cycle accepted write; updates the reference contents.
  task automatic write_vec(input string tag, input int addr, input logic [1:0] mask,
                           input logic [63:0] data);
    wr_valid = 1'b1;
    wr_addr  = AW'(addr);
    wr_mask  = mask;
    wr_data  = data;
    #1;
    chk({tag, "_ready"}, {63'b0, wr_ready}, 64'd1);
    step();
    wr_valid = 1'b0;
    wr_mask  = '0;
    for (int k = 0; k < LANES; k++)
      if (mask[k]) exp_mem[(addr + k) % NUM_ELEMS] = data[k*ELEM_W +: ELEM_W];
  endtask

  // One-cycle read on both ports against the reference contents.
  task automatic check_read(input string tag, input int a);
    rd_addr_a = AW'(a);
    rd_addr_b = AW'(a + 4);
    #1;
    chk({tag, "_a"}, rd_data_a, vec(a));
    chk({tag, "_b"}, rd_data_b, vec(a + 4));
    step();
  endtask

  initial begin
    int  waited;
    bit  got;

    rst_n = 1'b0; rd_addr_a = '0; rd_addr_b = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_mask = '0; wr_data = '0; clr_req = 1'b0;
    for (int i = 0; i < NUM_ELEMS; i++) exp_mem[i] = '0;

    // ---------------- reset state ----------------
    #2;
    chk("rst_rd_a",  rd_data_a, 64'h0);
    chk("rst_rd_b",  rd_data_b, 64'h0);
    chk("rst_busy",  {63'b0, busy}, 64'd0);
    chk("rst_ready", {63'b0, wr_ready}, 64'd1);
    step(); step();
    rst_n = 1'b1;
    step();

    // ---------------- wrap write ----------------
    write_vec("wrap_wr", 7, 2'b11, 64'h22222222_11111111);
    rd_addr_a = 3'd7; rd_addr_b = 3'd0;
    #1;
    chk("wrap_rd_a7", rd_data_a, 64'h22222222_11111111);
    chk("wrap_rd_b0", rd_data_b, 64'h00000000_22222222);
    step();

    // ---------------- mask ----------------
    write_vec("mask_fill", 3, 2'b01, 64'h00000000_DEADBEEF);
    write_vec("mask_hi",   3, 2'b10, 64'h0000CAFE_12345678);
    write_vec("mask_zero", 3, 2'b00, 64'hFFFFFFFF_FFFFFFFF);
    rd_addr_a = 3'd3;
    #1;
    chk("mask_rd", rd_data_a, 64'h0000CAFE_DEADBEEF);
    step();

    // ---------------- bypass / write latency ----------------
    rd_addr_b = 3'd5;
    wr_valid = 1'b1; wr_addr = 3'd5; wr_mask = 2'b11; wr_data = 64'h0000BBBB_0000AAAA;
    #1;
    chk("byp_ready", {63'b0, wr_ready}, 64'd1);
`ifdef VREG_BYPASS_EN
    chk("byp_same_cycle", rd_data_b, 64'h0000BBBB_0000AAAA);
`else
    chk("byp_same_cycle", rd_data_b, 64'h0);
`endif
    step();
    wr_valid = 1'b0; wr_mask = '0;
    exp_mem[5] = 32'h0000AAAA; exp_mem[6] = 32'h0000BBBB;
    #1;
    chk("byp_next_cycle", rd_data_b, 64'h0000BBBB_0000AAAA);
    step();

    // ---------------- fill all, then clear sweep ----------------
    write_vec("fill0", 0, 2'b11, 64'hC0DE0001_C0DE0000);
    write_vec("fill2", 2, 2'b11, 64'hC0DE0003_C0DE0002);
    write_vec("fill4", 4, 2'b11, 64'hC0DE0005_C0DE0004);
    write_vec("fill6", 6, 2'b11, 64'hC0DE0007_C0DE0006);
    check_read("fill_rd0", 0);
    check_read("fill_rd2", 2);

    clr_req = 1'b1;
    #1;
    chk("clr_start_ready", {63'b0, wr_ready}, 64'd0);
    chk("clr_start_busy",  {63'b0, busy}, 64'd0);
    step();
    clr_req = 1'b0;
    for (int c = 0; c < NUM_ELEMS; c++) begin
      rd_addr_a = AW'(c);
      rd_addr_b = AW'(c + 7);
      clr_req   = (c == 3);   // ignored while sweeping
`ifdef VREG_BYPASS_EN
      exp_mem[c] = '0;
`endif
      #1;
      chk($sformatf("sweep%0d_busy", c),  {63'b0, busy}, 64'd1);
      chk($sformatf("sweep%0d_ready", c), {63'b0, wr_ready}, 64'd0);
      chk($sformatf("sweep%0d_rd_a", c),  rd_data_a, vec(c));
      chk($sformatf("sweep%0d_rd_b", c),  rd_data_b, vec(c + 7));
      step();
      exp_mem[c] = '0;
    end
    clr_req = 1'b0;
    #1;
    chk("clr_end_busy",  {63'b0, busy}, 64'd0);
    chk("clr_end_ready", {63'b0, wr_ready}, 64'd1);
    step();
    check_read("clr_rd0", 0);
    check_read("clr_rd2", 2);

    // ---------------- contention ----------------
    clr_req = 1'b1;
    wr_valid = 1'b1; wr_addr = 3'd2; wr_mask = 2'b01; wr_data = 64'h00000000_55555555;
    #1;
    chk("cont_ready", {63'b0, wr_ready}, 64'd0);
    step();
    clr_req = 1'b0;
    waited = 0;
    got    = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      if (wr_ready === 1'b1) got = 1'b1;
      else begin
        waited++;
        step();
      end
    end
    chk("cont_accepted", {63'b0, got}, 64'd1);
    chk("cont_wait_cycles", 64'(waited), 64'd8);
    step();
    wr_valid = 1'b0; wr_mask = '0;
    exp_mem[2] = 32'h55555555;
    rd_addr_a = 3'd2;
    #1;
    chk("cont_elem2", rd_data_a, 64'h00000000_55555555);
    step();

    // ---------------- clr_req held across return to IDLE ----------------
    clr_req = 1'b1;
    step();
    for (int c = 0; c < NUM_ELEMS; c++) begin
      #1;
      chk($sformatf("hold%0d_busy", c), {63'b0, busy}, 64'd1);
      step();
    end
    #1;
    chk("hold_idle_busy",  {63'b0, busy}, 64'd0);
    chk("hold_idle_ready", {63'b0, wr_ready}, 64'd0);
    step();
    clr_req = 1'b0;
    #1;
    chk("hold_restart_busy", {63'b0, busy}, 64'd1);
    repeat (8) step();
    #1;
    chk("hold_done_busy", {63'b0, busy}, 64'd0);
    step();
    for (int i = 0; i < NUM_ELEMS; i++) exp_mem[i] = '0;

    // ---------------- reset mid-sweep ----------------
    write_vec("a5_0", 0, 2'b11, 64'hA5A5A5A5_A5A5A5A5);
    write_vec("a5_2", 2, 2'b11, 64'hA5A5A5A5_A5A5A5A5);
    write_vec("a5_4", 4, 2'b11, 64'hA5A5A5A5_A5A5A5A5);
    write_vec("a5_6", 6, 2'b11, 64'hA5A5A5A5_A5A5A5A5);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step(); step();
    rd_addr_a = 3'd6;
    #1;
    chk("mid_sweep_rd6", rd_data_a, 64'hA5A5A5A5_A5A5A5A5);
    chk("mid_sweep_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  {63'b0, busy}, 64'd0);
    chk("arst_ready", {63'b0, wr_ready}, 64'd1);
    chk("arst_rd6",   rd_data_a, 64'h0);
    step();
    rd_addr_a = 3'd0; rd_addr_b = 3'd2;
    #1;
    chk("arst_rd0", rd_data_a, 64'h0);
    chk("arst_rd2", rd_data_b, 64'h0);
    step();
    rd_addr_a = 3'd4; rd_addr_b = 3'd6;
    #1;
    chk("arst_rd4", rd_data_a, 64'h0);
    chk("arst_rd6b", rd_data_b, 64'h0);
    rst_n = 1'b1;
    step();
    #1;
    chk("post_rst_busy",  {63'b0, busy}, 64'd0);
    chk("post_rst_ready", {63'b0, wr_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_regfile_p.md
# vec_regfile_p

Parametrised vector register file for the vector datapath: NUM_ELEMS element registers of ELEM_W bits, read and written as LANES-wide vectors of consecutive elements starting at any element address, with wrap-around. Two combinational read ports serve the vector ALU operands. One masked write port with a valid/ready handshake serves write-back. A hardware clear sequencer zeroes the file one element per cycle without a reset.

## Interface
Parameters:
- ELEM_W, 32, element width in bits
- LANES, 2, elements per vector access; must satisfy 1 <= LANES <= NUM_ELEMS
- NUM_ELEMS, 8, element registers; must be a power of two
- AW, $clog2(NUM_ELEMS), element address width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr_a  in  AW  base element address, read port A
- rd_data_a  out  LANES*ELEM_W  lane k at bits [k*ELEM_W +: ELEM_W] = element (rd_addr_a+k) mod NUM_ELEMS
- rd_addr_b  in  AW  base element address, read port B
- rd_data_b  out  LANES*ELEM_W  same layout as port A
- wr_valid  in  1  write request
- wr_ready  out  1  write can be accepted this cycle
- wr_addr  in  AW  base element address for the write
- wr_mask  in  LANES  per-lane write enable; bit k enables lane k
- wr_data  in  LANES*ELEM_W  write data, same lane layout as the read ports
- clr_req  in  1  start a clear sweep; level-sampled
- busy  out  1  clear sweep in progress

## Operation
- Address arithmetic: lane k targets element (base + k) mod NUM_ELEMS, i.e. AW-bit truncating add. Address NUM_ELEMS-1 with LANES=2 targets elements NUM_ELEMS-1 and 0.
- Reads are purely combinational from the stored array; the two ports are independent.
- A write is accepted when wr_valid && wr_ready at a rising edge.
- On an accepted write, each lane with wr_mask[k]=1 stores its slice; lanes with wr_mask[k]=0 keep their value.
- An accepted write with wr_mask = 0 is legal and changes nothing.
- Since LANES <= NUM_ELEMS, no two lanes of one write target the same element.
- FSM states:
  - IDLE: wr_ready = !clr_req; busy = 0. On clr_req=1 go to SWEEP and load sweep_idx = 0.
  - SWEEP: wr_ready = 0; busy = 1. Each cycle zeroes element sweep_idx, then increments it. After zeroing element NUM_ELEMS-1, go to IDLE.
- Simultaneous clr_req and wr_valid in IDLE: clr_req wins. wr_ready is 0 that cycle and the write is not accepted; the master holds the request, per valid/ready rules.
- clr_req asserted while in SWEEP is ignored; no restart or extension.
- clr_req held high across the return to IDLE starts a new sweep immediately. The returning IDLE cycle has wr_ready = 0.
- Reads during SWEEP return current contents: elements below sweep_idx read as zero, the others read their old values.
- Reset asserted mid-sweep or mid-transfer aborts everything. All elements go to 0 and the state goes to IDLE.

## Timing
- Reset values:
  - all elements 0, so rd_data_a = rd_data_b = 0
  - state IDLE, sweep_idx 0
  - busy = 0; wr_ready = 1 (given clr_req = 0)
- Write latency: data accepted at edge N is visible on the read ports after edge N (combinational read in cycle N+1). With VREG_BYPASS_EN it is visible in cycle N; see Configuration.
- Clear latency: clr_req sampled high at edge N, then:
  - busy = 1 for exactly NUM_ELEMS cycles, from after edge N through edge N+NUM_ELEMS
  - element i is zeroed at edge N+1+i
  - busy = 0 and wr_ready = 1 after edge N+NUM_ELEMS
- Throughput: one write per cycle in IDLE; no write bubbles other than clr_req and SWEEP.

## Configuration
- Macro VREG_BYPASS_EN, when defined:
  - each read lane whose element matches an element being written this cycle returns the incoming wr_data slice combinationally
  - "being written" means an accepted write with that lane's mask bit set
  - a sweep zeroing the element this cycle also bypasses, returning 0
- When undefined: read ports reflect stored contents only; same-cycle writes appear one cycle later. This removes the read-port forwarding muxes.

## Test plan
- Reset: drop rst_n mid-sweep with elements holding 0xA5A5A5A5 -> all elements 0, busy=0 and wr_ready=1 immediately (asynchronously).
- Wrap write: LANES=2, NUM_ELEMS=8, wr_addr=7, wr_mask=2'b11, wr_data={0x22222222,0x11111111} -> element 7=0x11111111, element 0=0x22222222; reading rd_addr_a=7 returns the same vector.
- Mask: fill element 3=0xDEADBEEF, then write wr_addr=3, wr_mask=2'b10, data {0x0000CAFE,0x12345678} -> element 3 stays 0xDEADBEEF, element 4=0x0000CAFE.
- Clear: fill all 8 elements nonzero, pulse clr_req one cycle -> busy high exactly 8 cycles, element i reads 0 from the cycle after edge N+1+i, wr_ready=0 throughout.
- Contention: clr_req=1 and wr_valid=1 with wr_addr=2, data 0x55555555 in the same IDLE cycle -> write not accepted; holding wr_valid accepts it on the first IDLE cycle after the sweep, and element 2 ends at 0x55555555.
- Bypass: write wr_addr=5, data {0x0000BBBB,0x0000AAAA} while rd_addr_b=5 -> same cycle rd_data_b = {0x0000BBBB,0x0000AAAA} with VREG_BYPASS_EN, old contents without; both builds show the new value the next cycle.
